// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM state types and sizing helper for the pipeline stage controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {F_IDLE, F_WAIT, F_DROP} fetch_state_t;
  typedef enum logic {M_IDLE, M_WAIT} mem_state_t;
  function automatic int timeout_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction
endpackage

// File: rtl/pipe_fetch_fsm.sv
// pipe_fetch_fsm: single-outstanding fetch sequencer; drops a response whose fetch was overtaken by a redirect
module pipe_fetch_fsm
  import pipe_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d_free,
  input  logic redirect,
  input  logic if_rvalid,
  output logic if_req,
  output logic fetch_load
);
  fetch_state_t state, state_nxt;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= F_IDLE;
    else state <= state_nxt;
  // issue when D can take the response; a redirect while waiting turns the response into a drop
  always_comb begin
    state_nxt  = state;
    if_req     = 1'b0;
    fetch_load = 1'b0;
    unique case (state)
      F_IDLE: begin
        if_req    = d_free & ~redirect;
        state_nxt = if_req ? F_WAIT : F_IDLE;
      end
      F_WAIT: begin
        fetch_load = if_rvalid & ~redirect;
        state_nxt  = if_rvalid ? F_IDLE : redirect ? F_DROP : F_WAIT;
      end
      F_DROP: state_nxt = if_rvalid ? F_IDLE : F_DROP;
      default: state_nxt = F_IDLE;
    endcase
  end
endmodule

// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: F/D/E/M/W occupancy, advance and memory handshakes; perf counters built only with PIPE_PERF_CNT_EN
module pipe_stage_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_D,
  input  logic              redirect_E,
  output logic              if_req,
  input  logic              if_rvalid,
  input  logic              mem_req_M,
  output logic              mem_issue,
  input  logic              mem_done,
  output logic              en_FD,
  output logic              en_DE,
  output logic              en_EM,
  output logic              en_MW,
  output logic              pc_next,
  output logic              flush_FD,
  output logic              valid_E,
  output logic              valid_M,
  output logic              valid_W,
  output logic              ready_E,
  output logic              ready_M,
  output logic              ready_W,
  output logic              mem_timeout,
  output logic [PERF_W-1:0] perf_stall,
  output logic [PERF_W-1:0] perf_flush,
  output logic [PERF_W-1:0] perf_retire
);
  localparam int TIMEOUT_W = timeout_w(TIMEOUT);
  logic v_d, v_e, v_m, v_w;
  logic adv_d, adv_e, adv_m, redirect, fetch_load;
  logic [TIMEOUT_W-1:0] wait_cnt;
  mem_state_t mem_state, mem_state_nxt;
  logic waiting;
  assign adv_m    = v_m & (~mem_req_M | mem_done);
  assign adv_e    = v_e & (~v_m | adv_m);
  assign adv_d    = v_d & ~stall_D & (~v_e | adv_e);
  assign redirect = v_e & redirect_E & adv_e;
  assign en_FD    = fetch_load;
  assign en_DE    = adv_d & ~redirect;
  assign en_EM    = adv_e;
  assign en_MW    = adv_m;
  assign flush_FD = redirect;
  assign valid_E  = v_e;
  assign valid_M  = adv_m;
  assign valid_W  = v_w;
  assign ready_E  = ~v_e;
  assign ready_M  = ~v_m;
  assign ready_W  = ~v_w;
  assign pc_next  = if_req;
  assign waiting  = (mem_state == M_WAIT) & ~mem_done;
  pipe_fetch_fsm u_fetch (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_free     (~v_d | adv_d),
    .redirect   (redirect),
    .if_rvalid  (if_rvalid),
    .if_req     (if_req),
    .fetch_load (fetch_load)
  );
  // stage occupancy: a redirect squashes D and keeps it out of E
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {v_d, v_e, v_m, v_w} <= '0;
    else begin
      v_w <= adv_m;
      v_m <= adv_e | (v_m & ~adv_m);
      v_e <= en_DE | (v_e & ~adv_e);
      v_d <= ~redirect & (fetch_load | (v_d & ~adv_d));
    end
  // mem FSM: one strobe per access, an immediate ack never enters WAIT
  always_comb begin
    mem_issue     = (mem_state == M_IDLE) & v_m & mem_req_M;
    mem_state_nxt = (mem_state == M_IDLE) ? ((mem_issue & ~mem_done) ? M_WAIT : M_IDLE)
                                          : (mem_done ? M_IDLE : M_WAIT);
  end
  // mem state, saturating wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_state   <= M_IDLE;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      mem_state <= mem_state_nxt;
      if (mem_issue) wait_cnt <= '0;
      else if (waiting && wait_cnt != TIMEOUT_W'(TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
      if (waiting && wait_cnt == TIMEOUT_W'(TIMEOUT - 1)) mem_timeout <= 1'b1;
    end
`ifdef PIPE_PERF_CNT_EN
  // wrapping counters; a stall on an instruction being squashed is not counted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_stall  <= '0;
      perf_flush  <= '0;
      perf_retire <= '0;
    end else begin
      perf_stall  <= perf_stall + PERF_W'(v_d & stall_D & ~redirect);
      perf_flush  <= perf_flush + PERF_W'(redirect);
      perf_retire <= perf_retire + PERF_W'(v_w);
    end
`else
  assign perf_stall  = '0;
  assign perf_flush  = '0;
  assign perf_retire = '0;
`endif
endmodule
